// File: rtl/memory_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_unit_if
// Purpose  : Data bus bundle between the memory stage and the data memory.
//            Avalon-style read/write strobes with a waitrequest handshake.
// Signals  : data_address     word-aligned byte address (master -> slave)
//            data_read        read strobe               (master -> slave)
//            data_write       write strobe              (master -> slave)
//            data_writedata   lane-steered store data   (master -> slave)
//            data_byteenable  active byte lanes         (master -> slave)
//            data_waitrequest access not yet complete   (slave -> master)
//            data_readdata    read data                 (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface memory_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] data_address;
  logic                  data_read;
  logic                  data_write;
  logic [31:0]           data_writedata;
  logic [3:0]            data_byteenable;
  logic                  data_waitrequest;
  logic [31:0]           data_readdata;

  modport master (
    output data_address, data_read, data_write, data_writedata, data_byteenable,
    input  data_waitrequest, data_readdata
  );

  modport slave (
    input  data_address, data_read, data_write, data_writedata, data_byteenable,
    output data_waitrequest, data_readdata
  );
endinterface
`default_nettype wire

// File: rtl/memory_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_unit
// Purpose  : Memory pipeline stage. Issues one load/store per instruction on
//            the data bus, stalls upstream stages until the bus completes,
//            steers store lanes and aligns/extends load data for MEM/WB.
// Ports    : clk, reset                  clock, synchronous active-high reset
//            memory_to_register_memory   load request
//            memory_write_memory         store request (wins over load)
//            access_size_memory          00 byte, 01 half, 1x word
//            load_unsigned_memory        1 = zero-extend load result
//            ALU_output_memory           effective byte address
//            write_data_memory           store data (low bits for byte/half)
//            bus                         data bus, master side
//            read_data_memory            aligned, extended load result
//            stall_memory                hold upstream pipeline registers
//            address_error_memory        misaligned request (IDLE only)
// Revision : 1.0 - initial release
// ============================================================================
module memory_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        memory_to_register_memory,
  input  logic                        memory_write_memory,
  input  logic [1:0]                  access_size_memory,
  input  logic                        load_unsigned_memory,
  input  logic [31:0]                 ALU_output_memory,
  input  logic [31:0]                 write_data_memory,
  memory_access_unit_if.master        bus,
  output logic [31:0]                 read_data_memory,
  output logic                        stall_memory,
  output logic                        address_error_memory
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  read_q;
  logic                  write_q;
  logic [31:0]           writedata_q;
  logic [3:0]            byteenable_q;
  logic [31:0]           rdata_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [1:0]            offset_q;

  logic                  request_d;
  logic                  misaligned_d;
  logic                  accept_d;
  logic [3:0]            byteenable_d;
  logic [31:0]           writedata_d;
  logic [31:0]           shifted_d;
  logic [31:0]           load_d;
  logic [ADDR_WIDTH-1:0] word_addr_d;

  // Bus address is the effective address with the byte offset cleared,
  // truncated or zero-extended to the bus width.
  generate
    if (ADDR_WIDTH <= 32) begin : g_addr_narrow
      assign word_addr_d = {ALU_output_memory[ADDR_WIDTH-1:2], 2'b00};
    end else begin : g_addr_wide
      assign word_addr_d = {{(ADDR_WIDTH-32){1'b0}}, ALU_output_memory[31:2], 2'b00};
    end
  endgenerate

  always_comb begin
    request_d = memory_write_memory | memory_to_register_memory;
    case (access_size_memory)
      2'b00: begin
        misaligned_d = 1'b0;
        byteenable_d = 4'b0001 << ALU_output_memory[1:0];
        writedata_d  = {4{write_data_memory[7:0]}};
      end
      2'b01: begin
        misaligned_d = ALU_output_memory[0];
        byteenable_d = ALU_output_memory[1] ? 4'b1100 : 4'b0011;
        writedata_d  = {2{write_data_memory[15:0]}};
      end
      default: begin
        misaligned_d = |ALU_output_memory[1:0];
        byteenable_d = 4'b1111;
        writedata_d  = write_data_memory;
      end
    endcase
    accept_d = (state_q == IDLE) & request_d & ~misaligned_d;

    // Move the addressed lane down to bit 0, then extend to 32 bits.
    shifted_d = bus.data_readdata >> {offset_q, 3'b000};
    case (size_q)
      2'b00:   load_d = unsigned_q ? {24'd0, shifted_d[7:0]}
                                   : {{24{shifted_d[7]}}, shifted_d[7:0]};
      2'b01:   load_d = unsigned_q ? {16'd0, shifted_d[15:0]}
                                   : {{16{shifted_d[15]}}, shifted_d[15:0]};
      default: load_d = shifted_d;
    endcase
  end

  // Stall is combinational in IDLE so the upstream registers hold in the
  // very cycle the request is first seen; DONE releases them for one cycle.
  assign address_error_memory = (state_q == IDLE) & request_d & misaligned_d;
  assign stall_memory         = accept_d | (state_q == BUS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= 32'd0;
      byteenable_q <= 4'd0;
      rdata_q      <= 32'd0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      offset_q     <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            addr_q       <= word_addr_d;
            write_q      <= memory_write_memory;
            read_q       <= ~memory_write_memory;  // store wins over load
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            size_q       <= access_size_memory;
            unsigned_q   <= load_unsigned_memory;
            offset_q     <= ALU_output_memory[1:0];
            state_q      <= BUS;
          end
        end
        BUS: begin
          if (!bus.data_waitrequest) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            if (read_q) begin
              rdata_q <= load_d;
            end
            state_q <= DONE;
          end
        end
        // Always return to IDLE so the retiring instruction is not re-issued.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_address    = addr_q;
  assign bus.data_read       = read_q;
  assign bus.data_write      = write_q;
  assign bus.data_writedata  = writedata_q;
  assign bus.data_byteenable = byteenable_q;
  assign read_data_memory    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_access_unit
// Purpose  : Self-checking bench for memory_access_unit. Directed cases plus
//            randomized transactions against a byte-arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_i, st_i, uns_i;
  logic [1:0]  sz_i;
  logic [31:0] addr_i, wd_i;
  logic [31:0] read_data;
  logic        stall, aerr;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] rd_model;

  memory_access_unit_if #(.ADDR_WIDTH(32)) bus ();

  memory_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .memory_to_register_memory (ld_i),
    .memory_write_memory       (st_i),
    .access_size_memory        (sz_i),
    .load_unsigned_memory      (uns_i),
    .ALU_output_memory         (addr_i),
    .write_data_memory         (wd_i),
    .bus                       (bus),
    .read_data_memory          (read_data),
    .stall_memory              (stall),
    .address_error_memory      (aerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One instruction from first presentation in IDLE to release of the
  // request after DONE. Entry/exit at 2 time units after a rising edge.
  task automatic run_txn(input logic st, input logic ld, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int waits);
    int          nb;
    logic [31:0] mask, exp_wd, exp_rd;
    logic [3:0]  exp_be;
    logic        mis;
    longint      v;
    nb     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mask   = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    mis    = (addr % nb) != 0;
    exp_be = 4'(((1 << nb) - 1) << addr[1:0]);
    exp_wd = (nb == 4) ? wd : (wd & mask) * ((nb == 1) ? 32'h0101_0101 : 32'h0001_0001);
    v      = longint'((rd >> (8 * addr[1:0])) & mask);
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    exp_rd = v[31:0];

    st_i = st; ld_i = ld; sz_i = sz; uns_i = uns; addr_i = addr; wd_i = wd;
    bus.data_waitrequest = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
    bus.data_readdata    = $urandom;
    #1;
    chk("idle_err",   32'(aerr),           32'(mis));
    chk("idle_stall", 32'(stall),          32'(!mis));
    chk("idle_read",  32'(bus.data_read),  32'd0);
    chk("idle_write", 32'(bus.data_write), 32'd0);

    if (mis) begin
      @(posedge clk); #1;
      bus.data_waitrequest = 1'b0;
      #1;
      chk("mis_read",  32'(bus.data_read),  32'd0);
      chk("mis_write", 32'(bus.data_write), 32'd0);
      chk("mis_err",   32'(aerr),           32'd1);
      chk("mis_stall", 32'(stall),          32'd0);
    end else begin
      for (int c = 0; c <= waits; c++) begin
        @(posedge clk); #1;
        bus.data_waitrequest = (c < waits) ? 1'b1 : 1'b0;
        bus.data_readdata    = (c < waits) ? $urandom : rd;
        #1;
        chk("bus_read",  32'(bus.data_read),       32'(!st));
        chk("bus_write", 32'(bus.data_write),      32'(st));
        chk("bus_addr",  bus.data_address,         addr & 32'hFFFF_FFFC);
        chk("bus_be",    32'(bus.data_byteenable), 32'(exp_be));
        if (st) chk("bus_wdata", bus.data_writedata, exp_wd);
        chk("bus_stall", 32'(stall),               32'd1);
        chk("bus_err",   32'(aerr),                32'd0);
        chk("bus_rdata", read_data,                rd_model);
      end
      @(posedge clk); #1;
      bus.data_waitrequest = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
      bus.data_readdata    = $urandom;
      if (!st) rd_model = exp_rd;
      #1;
      chk("done_read",  32'(bus.data_read),  32'd0);
      chk("done_write", 32'(bus.data_write), 32'd0);
      chk("done_stall", 32'(stall),          32'd0);
      chk("done_err",   32'(aerr),           32'd0);
      chk("done_rdata", read_data,           rd_model);
    end

    @(posedge clk); #1;
    st_i = 1'b0; ld_i = 1'b0;
    #1;
    chk("post_stall", 32'(stall),          32'd0);
    chk("post_read",  32'(bus.data_read),  32'd0);
    chk("post_write", 32'(bus.data_write), 32'd0);
    chk("post_rdata", read_data,           rd_model);
  endtask

  initial begin
    logic st, ld;
    reset = 1'b1;
    st_i = 1'b0; ld_i = 1'b0; uns_i = 1'b0; sz_i = 2'd0; addr_i = 32'd0; wd_i = 32'd0;
    bus.data_waitrequest = 1'b0;
    bus.data_readdata    = 32'd0;
    rd_model = 32'd0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    #1;
    chk("rst_addr",  bus.data_address,         32'd0);
    chk("rst_read",  32'(bus.data_read),       32'd0);
    chk("rst_write", 32'(bus.data_write),      32'd0);
    chk("rst_wdata", bus.data_writedata,       32'd0);
    chk("rst_be",    32'(bus.data_byteenable), 32'd0);
    chk("rst_rdata", read_data,                32'd0);
    chk("rst_stall", 32'(stall),               32'd0);
    chk("rst_err",   32'(aerr),                32'd0);

    // Directed cases
    run_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_1004, 32'd0,         32'h8123_4567, 0);
    run_txn(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_1007, 32'd0,         32'h80FF_FFFF, 0);
    run_txn(1'b0, 1'b1, 2'd0, 1'b1, 32'h0000_1007, 32'd0,         32'h80FF_FFFF, 1);
    run_txn(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF, 32'd0,         3);
    run_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_1001, 32'd0,         32'd0,         0);
    run_txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_1003, 32'd0,         32'd0,         0);
    run_txn(1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'h1234_5678, 32'hFFFF_FFFF, 1);
    run_txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_3002, 32'd0,         32'h8001_7FFF, 2);

    // Reset while a load is waiting on the bus
    st_i = 1'b0; ld_i = 1'b1; sz_i = 2'd2; uns_i = 1'b0; addr_i = 32'h0000_3000;
    bus.data_waitrequest = 1'b1;
    #1;
    chk("rbus_idle_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    #1;
    chk("rbus_read", 32'(bus.data_read), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rd_model = 32'd0;
    #1;
    chk("rbus_read_after", 32'(bus.data_read), 32'd0);
    chk("rbus_addr_after", bus.data_address,   32'd0);
    chk("rbus_stall_fresh", 32'(stall),        32'd1);
    chk("rbus_rdata",       read_data,         32'd0);
    ld_i = 1'b0;
    #1;
    chk("rbus_stall_noreq", 32'(stall), 32'd0);
    @(posedge clk); #1;
    #1;
    chk("rbus_read_later", 32'(bus.data_read), 32'd0);

    // Randomized transactions
    for (int i = 0; i < 150; i++) begin
      st = ($urandom_range(0, 1) == 1);
      ld = st ? ($urandom_range(0, 1) == 1) : 1'b1;
      run_txn(st, ld, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Memory-stage block that consumes the EX/MEM pipeline register outputs.
- Performs load/store accesses on a data bus with a waitrequest handshake, and stalls the pipeline until each access completes.
- Handles byte lane steering, byte enables and load sign/zero extension.
- Delivers aligned load data to the MEM/WB register.

Parameters:
- ADDR_WIDTH, 32, width of data bus address output.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- memory_to_register_memory  in  1  load request (from EX/MEM register).
- memory_write_memory  in  1  store request (from EX/MEM register).
- access_size_memory  in  2  00 byte, 01 halfword, 10/11 word.
- load_unsigned_memory  in  1  1 = zero-extend load, 0 = sign-extend.
- ALU_output_memory  in  32  effective byte address.
- write_data_memory  in  32  store data; low bits are valid for byte/half.
- data_address  out  ADDR_WIDTH  word-aligned bus address (addr[1:0] forced to 00).
- data_read  out  1  bus read strobe.
- data_write  out  1  bus write strobe.
- data_writedata  out  32  lane-steered store data.
- data_byteenable  out  4  active byte lanes.
- data_waitrequest  in  1  1 = bus not yet accepting or completing the access.
- data_readdata  in  32  bus read data, valid when data_read=1 and data_waitrequest=0.
- read_data_memory  out  32  aligned and extended load result.
- stall_memory  out  1  1 = hold all upstream pipeline registers.
- address_error_memory  out  1  misaligned access flagged.

Behaviour:
- Lane mapping: byte at address offset k occupies bits [8k+7:8k] (lane k).
- FSM states: IDLE, BUS, DONE. Reset forces IDLE.
- Reset values: data_read=0, data_write=0, data_address=0, data_writedata=0, data_byteenable=0, read_data_memory=0.
- IDLE:
  - Request = memory_write_memory OR memory_to_register_memory.
  - If both are set, the store wins and no read is issued.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=00): address_error_memory=1 combinationally, stall_memory=0, no bus access, stay IDLE.
  - Aligned request: stall_memory=1. Register address, strobes, writedata and byteenable. Latch size, unsigned flag and addr[1:0]. Go to BUS.
  - No request: stall_memory=0.
- BUS:
  - data_read or data_write is held high and all bus outputs are held stable while data_waitrequest=1.
  - stall_memory=1.
  - When data_waitrequest=0: drop strobes next cycle and go to DONE.
  - For a load, capture data_readdata shifted right by 8*addr[1:0], then extended per the latched size/unsigned into read_data_memory.
- DONE:
  - stall_memory=0 for exactly one cycle; the pipeline advances past this instruction.
  - read_data_memory is valid and holds its value until the next load capture.
  - Next state is IDLE. A new request is evaluated only from IDLE, so the same instruction is never re-issued.
- Latency:
  - Aligned access with zero wait states has stall high for 2 cycles (IDLE, BUS) and is released in cycle 3 (DONE).
  - Each waitrequest cycle adds 1 cycle.
- Store steering:
  - Byte: data_writedata = {4{wd[7:0]}}, byteenable = 1 << addr[1:0].
  - Half: data_writedata = {2{wd[15:0]}}, byteenable = 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - Word: data_writedata = wd, byteenable = 1111.
- Loads drive data_byteenable the same as stores of the same size; data_writedata is don't-care.
- data_read and data_write are never high simultaneously. Both are 0 outside BUS.
- Reset asserted in BUS or DONE: next cycle state=IDLE and strobes=0. A bus transaction in flight is abandoned.
- address_error_memory is purely combinational from IDLE inputs and is 0 in BUS and DONE.

Test Plan:
- Reset held 2 cycles, then released with no request -> all bus outputs 0, stall_memory=0, read_data_memory=0.
- Word load at addr 0x0000_1004, waitrequest=0, readdata=0x8123_4567 -> data_address=0x1004, byteenable=1111, stall high 2 cycles, DONE read_data_memory=0x8123_4567.
- Signed byte load at 0x1007, readdata=0x80FF_FFFF -> byteenable=1000, read_data_memory=0xFFFF_FF80. Repeat unsigned -> 0x0000_0080.
- Half store at 0x2002, wd=0xDEAD_BEEF, waitrequest high 3 cycles -> data_write and outputs stable for 4 BUS cycles, writedata=0xBEEF_BEEF, byteenable=1100, stall high 5 cycles total.
- Word load at 0x1001 -> address_error_memory=1 same cycle, stall_memory=0, data_read never asserts.
- Load in BUS with waitrequest=1, reset pulsed -> next cycle data_read=0, state IDLE, stall_memory reflects fresh IDLE evaluation.
